// File: rtl/goofy_alu_pkg.sv
// goofy_alu_pkg - shared definitions for the Goofy CPU ALU.
//   ALU_WIDTH  : datapath width of operands and result
//   alu_op_e   : operation select driven by the strobe priority encoder
//   sel_op     : strobe priority encoder (add > add_ov > sub > sub_ov >
//                and > or > not > cmp)
//   is_result_op : true for operations that write alu_out
package goofy_alu_pkg;

  localparam int ALU_WIDTH = 8;

  typedef enum logic [3:0] {
    OP_NONE   = 4'd0,
    OP_ADD    = 4'd1,
    OP_ADD_OV = 4'd2,
    OP_SUB    = 4'd3,
    OP_SUB_OV = 4'd4,
    OP_AND    = 4'd5,
    OP_OR     = 4'd6,
    OP_NOT    = 4'd7,
    OP_CMP    = 4'd8
  } alu_op_e;

  // strb bit order: [0]=add [1]=add_ov [2]=sub [3]=sub_ov
  //                 [4]=and [5]=or [6]=not [7]=cmp
  // Lower bit index wins when several strobes are high.
  function automatic alu_op_e sel_op(input logic [7:0] strb);
    alu_op_e op;
    if (strb[0])      op = OP_ADD;
    else if (strb[1]) op = OP_ADD_OV;
    else if (strb[2]) op = OP_SUB;
    else if (strb[3]) op = OP_SUB_OV;
    else if (strb[4]) op = OP_AND;
    else if (strb[5]) op = OP_OR;
    else if (strb[6]) op = OP_NOT;
    else if (strb[7]) op = OP_CMP;
    else              op = OP_NONE;
    return op;
  endfunction

  function automatic logic is_result_op(input alu_op_e op);
    return (op != OP_NONE) && (op != OP_CMP);
  endfunction

  function automatic logic is_arith_op(input alu_op_e op);
    return (op == OP_ADD) || (op == OP_ADD_OV) ||
           (op == OP_SUB) || (op == OP_SUB_OV);
  endfunction

endpackage

// File: rtl/goofy_alu_calc.sv
// goofy_alu_calc - purely combinational ALU datapath.
//   a, b    : operands
//   cin     : carry/borrow in, used only by OP_ADD_OV / OP_SUB_OV
//   op      : operation select
//   result  : WIDTH-bit result (zero for OP_NONE / OP_CMP)
//   cout    : carry-out for adds, borrow for subtracts
//   eq      : a == b
module goofy_alu_calc
  import goofy_alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  alu_op_e          op,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             eq
);

  logic [WIDTH:0] ext_a;
  logic [WIDTH:0] ext_b;
  logic [WIDTH:0] ext_c;
  logic [WIDTH:0] wide;

  // One extra bit catches the carry; for subtraction a negative
  // difference wraps to a value with the top bit set, i.e. the borrow.
  always_comb begin
    ext_a = {1'b0, a};
    ext_b = {1'b0, b};
    ext_c = {{WIDTH{1'b0}}, cin};
    wide  = '0;
    case (op)
      OP_ADD:    wide = ext_a + ext_b;
      OP_ADD_OV: wide = ext_a + ext_b + ext_c;
      OP_SUB:    wide = ext_a - ext_b;
      OP_SUB_OV: wide = ext_a - ext_b - ext_c;
      OP_AND:    wide = {1'b0, a & b};
      OP_OR:     wide = {1'b0, a | b};
      OP_NOT:    wide = {1'b0, ~a};
      default:   wide = '0;
    endcase
    result = wide[WIDTH-1:0];
    cout   = wide[WIDTH];
    eq     = (a == b);
  end

endmodule

// File: rtl/goofy_alu.sv
// goofy_alu - 8-bit ALU of the Goofy CPU core.
//   clk, res            : clock, synchronous active-high reset
//   alu0w/alu0d/alu0o   : operand A load strobe, data, register
//   alu1w/alu1d/alu1o   : operand B load strobe, data, register
//   alu_add .. alu_cmp  : one-cycle operation strobes (fixed priority)
//   alu_hlt             : sets the sticky halt flag
//   alu_flag_res        : clears ov/eq (and zero) flags, wins over ops
//   alu_out             : registered result
//   alu_flag_ov_o/eq_o/hlt_o : status flags
// Optional: GOOFY_ALU_ZERO_FLAG_EN adds alu_flag_zero_o, set when a
// result-producing operation yields zero.
module goofy_alu
  import goofy_alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             res,
  input  logic             alu0w,
  input  logic [WIDTH-1:0] alu0d,
  output logic [WIDTH-1:0] alu0o,
  input  logic             alu1w,
  input  logic [WIDTH-1:0] alu1d,
  output logic [WIDTH-1:0] alu1o,
  input  logic             alu_add,
  input  logic             alu_add_ov,
  input  logic             alu_sub,
  input  logic             alu_sub_ov,
  input  logic             alu_and,
  input  logic             alu_or,
  input  logic             alu_not,
  input  logic             alu_cmp,
  input  logic             alu_hlt,
  input  logic             alu_flag_res,
  output logic [WIDTH-1:0] alu_out,
  output logic             alu_flag_ov_o,
  output logic             alu_flag_eq_o,
`ifdef GOOFY_ALU_ZERO_FLAG_EN
  output logic             alu_flag_zero_o,
`endif
  output logic             alu_flag_hlt_o
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             ov_q, ov_d;
  logic             eq_q, eq_d;
  logic             hlt_q, hlt_d;

  logic [7:0]       strb;
  alu_op_e          op;
  logic [WIDTH-1:0] calc_res;
  logic             calc_cout;
  logic             calc_eq;

  assign strb = {alu_cmp, alu_not, alu_or, alu_and,
                 alu_sub_ov, alu_sub, alu_add_ov, alu_add};
  assign op   = sel_op(strb);

  // Operates on the registered operands, so a same-edge operand write
  // is not visible to the operation.
  goofy_alu_calc #(.WIDTH(WIDTH)) u_calc (
    .a      (a_q),
    .b      (b_q),
    .cin    (ov_q),
    .op     (op),
    .result (calc_res),
    .cout   (calc_cout),
    .eq     (calc_eq)
  );

  always_comb begin
    a_d   = alu0w ? alu0d : a_q;
    b_d   = alu1w ? alu1d : b_q;
    out_d = out_q;
    ov_d  = ov_q;
    eq_d  = eq_q;
    hlt_d = hlt_q | alu_hlt;
    if (is_result_op(op)) out_d = calc_res;
    if (is_arith_op(op))  ov_d  = calc_cout;
    if (op == OP_CMP)     eq_d  = calc_eq;
    if (alu_flag_res) begin
      ov_d = 1'b0;
      eq_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      a_q   <= '0;
      b_q   <= '0;
      out_q <= '0;
      ov_q  <= 1'b0;
      eq_q  <= 1'b0;
      hlt_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      out_q <= out_d;
      ov_q  <= ov_d;
      eq_q  <= eq_d;
      hlt_q <= hlt_d;
    end
  end

`ifdef GOOFY_ALU_ZERO_FLAG_EN
  logic zero_q, zero_d;

  always_comb begin
    zero_d = zero_q;
    if (is_result_op(op)) zero_d = (calc_res == '0);
    if (alu_flag_res)     zero_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (res) zero_q <= 1'b0;
    else     zero_q <= zero_d;
  end

  assign alu_flag_zero_o = zero_q;
`endif

  assign alu0o          = a_q;
  assign alu1o          = b_q;
  assign alu_out        = out_q;
  assign alu_flag_ov_o  = ov_q;
  assign alu_flag_eq_o  = eq_q;
  assign alu_flag_hlt_o = hlt_q;

endmodule

// File: tb/tb_goofy_alu.sv
module tb_goofy_alu;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       alu0w = 1'b0, alu1w = 1'b0;
  logic [7:0] alu0d = '0, alu1d = '0;
  logic [7:0] alu0o, alu1o, alu_out;
  logic       alu_add = 0, alu_add_ov = 0, alu_sub = 0, alu_sub_ov = 0;
  logic       alu_and = 0, alu_or = 0, alu_not = 0, alu_cmp = 0;
  logic       alu_hlt = 0, alu_flag_res = 0;
  logic       alu_flag_ov_o, alu_flag_eq_o, alu_flag_hlt_o;
`ifdef GOOFY_ALU_ZERO_FLAG_EN
  logic       alu_flag_zero_o;
`endif

  always #5 clk = ~clk;

  goofy_alu dut (
    .clk            (clk),
    .res            (res),
    .alu0w          (alu0w),
    .alu0d          (alu0d),
    .alu0o          (alu0o),
    .alu1w          (alu1w),
    .alu1d          (alu1d),
    .alu1o          (alu1o),
    .alu_add        (alu_add),
    .alu_add_ov     (alu_add_ov),
    .alu_sub        (alu_sub),
    .alu_sub_ov     (alu_sub_ov),
    .alu_and        (alu_and),
    .alu_or         (alu_or),
    .alu_not        (alu_not),
    .alu_cmp        (alu_cmp),
    .alu_hlt        (alu_hlt),
    .alu_flag_res   (alu_flag_res),
    .alu_out        (alu_out),
    .alu_flag_ov_o  (alu_flag_ov_o),
    .alu_flag_eq_o  (alu_flag_eq_o),
`ifdef GOOFY_ALU_ZERO_FLAG_EN
    .alu_flag_zero_o(alu_flag_zero_o),
`endif
    .alu_flag_hlt_o (alu_flag_hlt_o)
  );

  // strobe bits for the step task
  localparam logic [9:0] S_NONE = 10'h000;
  localparam logic [9:0] S_ADD  = 10'h001;
  localparam logic [9:0] S_ADDC = 10'h002;
  localparam logic [9:0] S_SUB  = 10'h004;
  localparam logic [9:0] S_SUBB = 10'h008;
  localparam logic [9:0] S_AND  = 10'h010;
  localparam logic [9:0] S_OR   = 10'h020;
  localparam logic [9:0] S_NOT  = 10'h040;
  localparam logic [9:0] S_CMP  = 10'h080;
  localparam logic [9:0] S_HLT  = 10'h100;
  localparam logic [9:0] S_FRES = 10'h200;

  typedef struct {
    string      name;
    logic [7:0] a, b, out;
    logic       ov, eq, hlt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, req);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, req);
    end
  endtask

  // Monitor: outputs are registered, so they are stable at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk8({e.name, ".a"},   alu0o,          e.a);
        chk8({e.name, ".b"},   alu1o,          e.b);
        chk8({e.name, ".out"}, alu_out,        e.out);
        chk1({e.name, ".ov"},  alu_flag_ov_o,  e.ov);
        chk1({e.name, ".eq"},  alu_flag_eq_o,  e.eq);
        chk1({e.name, ".hlt"}, alu_flag_hlt_o, e.hlt);
      end
    end
  end

  task automatic step(input string name, input logic r,
                      input logic w0, input logic [7:0] d0,
                      input logic w1, input logic [7:0] d1,
                      input logic [9:0] s,
                      input logic [7:0] ea, input logic [7:0] eb,
                      input logic [7:0] eout,
                      input logic eov, input logic eeq, input logic ehlt);
    exp_t e;
    @(negedge clk);
    res = r;
    alu0w = w0; alu0d = d0; alu1w = w1; alu1d = d1;
    {alu_flag_res, alu_hlt, alu_cmp, alu_not, alu_or, alu_and,
     alu_sub_ov, alu_sub, alu_add_ov, alu_add} = s;
    @(posedge clk);
    #1;
    res = 1'b0; alu0w = 1'b0; alu1w = 1'b0;
    {alu_flag_res, alu_hlt, alu_cmp, alu_not, alu_or, alu_and,
     alu_sub_ov, alu_sub, alu_add_ov, alu_add} = '0;
    e.name = name; e.a = ea; e.b = eb; e.out = eout;
    e.ov = eov; e.eq = eeq; e.hlt = ehlt;
    exp_q.push_back(e);
  endtask

  initial begin
    int budget;
    //    name        res w0 d0     w1 d1     strobes            a      b      out    ov eq hlt
    step("rst0",      1, 0, 8'h00, 0, 8'h00, S_NONE,            8'h00, 8'h00, 8'h00, 0, 0, 0);
    step("pre_ld",    0, 1, 8'hC0, 1, 8'h80, S_NONE,            8'hC0, 8'h80, 8'h00, 0, 0, 0);
    step("pre_add",   0, 0, 8'h00, 0, 8'h00, S_ADD,             8'hC0, 8'h80, 8'h40, 1, 0, 0);
    step("pre_ldb",   0, 0, 8'h00, 1, 8'hC0, S_NONE,            8'hC0, 8'hC0, 8'h40, 1, 0, 0);
    step("pre_cmp",   0, 0, 8'h00, 0, 8'h00, S_CMP,             8'hC0, 8'hC0, 8'h40, 1, 1, 0);
    step("pre_hlt",   0, 0, 8'h00, 0, 8'h00, S_HLT,             8'hC0, 8'hC0, 8'h40, 1, 1, 1);
    step("rst_over",  1, 1, 8'h11, 1, 8'h22, S_ADD | S_HLT,     8'h00, 8'h00, 8'h00, 0, 0, 0);
    step("ld_0a05",   0, 1, 8'h0A, 1, 8'h05, S_NONE,            8'h0A, 8'h05, 8'h00, 0, 0, 0);
    step("add_0f",    0, 0, 8'h00, 0, 8'h00, S_ADD,             8'h0A, 8'h05, 8'h0F, 0, 0, 0);
    step("sub_05",    0, 0, 8'h00, 0, 8'h00, S_SUB,             8'h0A, 8'h05, 8'h05, 0, 0, 0);
    step("ld_a03",    0, 1, 8'h03, 0, 8'h00, S_NONE,            8'h03, 8'h05, 8'h05, 0, 0, 0);
    step("sub_brw",   0, 0, 8'h00, 0, 8'h00, S_SUB,             8'h03, 8'h05, 8'hFE, 1, 0, 0);
    step("ld_ff01",   0, 1, 8'hFF, 1, 8'h01, S_NONE,            8'hFF, 8'h01, 8'hFE, 1, 0, 0);
    step("add_wrap",  0, 0, 8'h00, 0, 8'h00, S_ADD,             8'hFF, 8'h01, 8'h00, 1, 0, 0);
    step("ld_1020",   0, 1, 8'h10, 1, 8'h20, S_NONE,            8'h10, 8'h20, 8'h00, 1, 0, 0);
    step("addc_31",   0, 0, 8'h00, 0, 8'h00, S_ADDC,            8'h10, 8'h20, 8'h31, 0, 0, 0);
    step("subb_f0",   0, 0, 8'h00, 0, 8'h00, S_SUBB,            8'h10, 8'h20, 8'hF0, 1, 0, 0);
    step("subb_ef",   0, 0, 8'h00, 0, 8'h00, S_SUBB,            8'h10, 8'h20, 8'hEF, 1, 0, 0);
    step("fres_ov",   0, 0, 8'h00, 0, 8'h00, S_FRES,            8'h10, 8'h20, 8'hEF, 0, 0, 0);
    step("ld_f03c",   0, 1, 8'hF0, 1, 8'h3C, S_NONE,            8'hF0, 8'h3C, 8'hEF, 0, 0, 0);
    step("and_30",    0, 0, 8'h00, 0, 8'h00, S_AND,             8'hF0, 8'h3C, 8'h30, 0, 0, 0);
    step("or_fc",     0, 0, 8'h00, 0, 8'h00, S_OR,              8'hF0, 8'h3C, 8'hFC, 0, 0, 0);
    step("not_0f",    0, 0, 8'h00, 0, 8'h00, S_NOT,             8'hF0, 8'h3C, 8'h0F, 0, 0, 0);
    step("cmp_ne",    0, 0, 8'h00, 0, 8'h00, S_CMP,             8'hF0, 8'h3C, 8'h0F, 0, 0, 0);
    step("ld_bf0",    0, 0, 8'h00, 1, 8'hF0, S_NONE,            8'hF0, 8'hF0, 8'h0F, 0, 0, 0);
    step("cmp_eq",    0, 0, 8'h00, 0, 8'h00, S_CMP,             8'hF0, 8'hF0, 8'h0F, 0, 1, 0);
    step("idle_hold", 0, 0, 8'h00, 0, 8'h00, S_NONE,            8'hF0, 8'hF0, 8'h0F, 0, 1, 0);
    step("fres_eq",   0, 0, 8'h00, 0, 8'h00, S_FRES,            8'hF0, 8'hF0, 8'h0F, 0, 0, 0);
    step("ld_0202",   0, 1, 8'h02, 1, 8'h02, S_NONE,            8'h02, 8'h02, 8'h0F, 0, 0, 0);
    step("ld_add",    0, 1, 8'h01, 0, 8'h00, S_ADD,             8'h01, 8'h02, 8'h04, 0, 0, 0);
    step("add_and",   0, 0, 8'h00, 0, 8'h00, S_ADD | S_AND,     8'h01, 8'h02, 8'h03, 0, 0, 0);
    step("ld_b01",    0, 0, 8'h00, 1, 8'h01, S_NONE,            8'h01, 8'h01, 8'h03, 0, 0, 0);
    step("cmp_eq2",   0, 0, 8'h00, 0, 8'h00, S_CMP,             8'h01, 8'h01, 8'h03, 0, 1, 0);
    step("cmp_fres",  0, 0, 8'h00, 0, 8'h00, S_CMP | S_FRES,    8'h01, 8'h01, 8'h03, 0, 0, 0);
    step("ld_aff",    0, 1, 8'hFF, 0, 8'h00, S_NONE,            8'hFF, 8'h01, 8'h03, 0, 0, 0);
    step("add_fres",  0, 0, 8'h00, 0, 8'h00, S_ADD | S_FRES,    8'hFF, 8'h01, 8'h00, 0, 0, 0);
    step("sub_subb",  0, 0, 8'h00, 0, 8'h00, S_SUB | S_SUBB | S_OR, 8'hFF, 8'h01, 8'hFE, 0, 0, 0);
    step("and_or_not",0, 0, 8'h00, 0, 8'h00, S_AND | S_OR | S_NOT | S_CMP, 8'hFF, 8'h01, 8'h01, 0, 0, 0);
    step("not_cmp",   0, 0, 8'h00, 0, 8'h00, S_NOT | S_CMP,     8'hFF, 8'h01, 8'h00, 0, 0, 0);
    step("hlt_set",   0, 0, 8'h00, 0, 8'h00, S_HLT,             8'hFF, 8'h01, 8'h00, 0, 0, 1);
    step("hlt_add",   0, 0, 8'h00, 0, 8'h00, S_ADD,             8'hFF, 8'h01, 8'h00, 1, 0, 1);
    step("hlt_fres",  0, 0, 8'h00, 0, 8'h00, S_FRES,            8'hFF, 8'h01, 8'h00, 0, 0, 1);
    step("hlt_hold",  0, 0, 8'h00, 0, 8'h00, S_HLT | S_ADD,     8'hFF, 8'h01, 8'h00, 1, 0, 1);
    step("rst_hlt",   1, 0, 8'h00, 0, 8'h00, S_NONE,            8'h00, 8'h00, 8'h00, 0, 0, 0);
    step("idle_end",  0, 0, 8'h00, 0, 8'h00, S_NONE,            8'h00, 8'h00, 8'h00, 0, 0, 0);

    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
